// File: rtl/timer_panel.sv
// timer_panel: debounced front-panel editor that presets, loads and supervises the h/m/s timer.
// One debounce lane per button feeds a single-action, priority-resolved control FSM.

module timer_panel_btn #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic cut_n,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          stable;

    // press fires in the same edge that the stable value rises
    always_ff @(posedge clk) begin
        if (!cut_n) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                cnt    <= '0;
                stable <= sync[1];
                press  <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module timer_panel #(
    parameter int WIDTH      = 16,
    parameter int HOUR_MAX   = 99,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             cut_n,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic             btn_dec,
    input  logic             btn_go,
    input  logic             btn_stop,
    input  logic             buzy_n,
    input  logic             alarm,
    output logic [WIDTH-1:0] insec,
    output logic [WIDTH-1:0] inmin,
    output logic [WIDTH-1:0] inhour,
    output logic             up,
    output logic             write,
    output logic             start,
    output logic             abort,
    output logic [1:0]       field,
    output logic [1:0]       state,
    output logic             done_led
);
    typedef enum logic [1:0] {EDIT = 2'd0, ARM = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

    localparam int NUM_BTN = 5;
    localparam int B_STOP = 0, B_GO = 1, B_MODE = 2, B_INC = 3, B_DEC = 4;
    localparam logic [1:0] F_SEC = 2'd0, F_MIN = 2'd1, F_HOUR = 2'd2;
    localparam logic [WIDTH-1:0] SEC_MAX = WIDTH'(59);
    localparam logic [WIDTH-1:0] HR_MAX  = WIDTH'(HOUR_MAX);

    state_t             st;
    logic [NUM_BTN-1:0] raw, press, act;

    assign raw = {btn_dec, btn_inc, btn_mode, btn_go, btn_stop};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        timer_panel_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
            .clk  (clk),
            .cut_n(cut_n),
            .raw  (raw[i]),
            .press(press[i])
        );
    end

    // keep only the lowest-index press: stop > go > mode > inc > dec
    assign act   = press & (~press + NUM_BTN'(1));
    assign state = st;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v,
                                              input logic [WIDTH-1:0] lim,
                                              input logic             dn);
        if (dn) return (v == '0) ? lim : v - 1'b1;
        else    return (v >= lim) ? '0 : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!cut_n) begin
            st       <= EDIT;
            insec    <= '0;
            inmin    <= '0;
            inhour   <= '0;
            up       <= 1'b1;
            field    <= F_SEC;
            write    <= 1'b0;
            start    <= 1'b0;
            abort    <= 1'b0;
            done_led <= 1'b0;
        end else begin
            write <= 1'b0;
            start <= 1'b0;
            abort <= 1'b0;
            case (st)
                EDIT: begin
                    if (act[B_STOP]) begin
                        insec  <= '0;
                        inmin  <= '0;
                        inhour <= '0;
                        abort  <= 1'b1;
                    end else if (act[B_GO]) begin
                        if (buzy_n) begin
                            write <= 1'b1;
                            st    <= ARM;
                        end
                    end else if (act[B_MODE]) begin
                        field <= field + 2'd1;
                    end else if (act[B_INC] || act[B_DEC]) begin
                        case (field)
                            F_SEC:   insec  <= step(insec,  SEC_MAX, act[B_DEC]);
                            F_MIN:   inmin  <= step(inmin,  SEC_MAX, act[B_DEC]);
                            F_HOUR:  inhour <= step(inhour, HR_MAX,  act[B_DEC]);
                            default: up     <= ~up;
                        endcase
                    end
                end
                // write cycle issues start; the start cycle moves on to RUN
                ARM: begin
                    if (act[B_STOP]) begin
                        abort <= 1'b1;
                        st    <= EDIT;
                    end else if (write) begin
                        start <= 1'b1;
                    end else begin
                        st <= RUN;
                    end
                end
                RUN: begin
                    if (act[B_STOP]) begin
                        abort <= 1'b1;
                        st    <= EDIT;
                    end else if (alarm) begin
                        st       <= DONE;
                        done_led <= 1'b1;
                    end
                end
                DONE: begin
                    if (|press) begin
                        st       <= EDIT;
                        done_led <= 1'b0;
                    end
                end
                default: st <= EDIT;
            endcase
        end
    end
endmodule
